tff_counter_ctrl: RTL and testbench

Sequencing controller that drives a bank of toggle flip-flop cells as a programmable modulo-N up/down counter. Each cycle it computes the per-bit toggle enables from the current count, direction and modulus. A small FSM provides start/stop/one-shot control. The block is the standard way the team builds counters, dividers and timers from T cells, instead of writing adders inline.

---
 rtl/tff_pkg.sv | 24 ++
 rtl/tff_cell.sv | 24 ++
 rtl/tff_counter_ctrl.sv | 130 +++++++++++++
 tb/tb_tff_counter_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop counter controller: FSM state
// encoding and the load-value clamp helper.
package tff_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Clamp a load value into 0..modulus-1. Operates on the widest supported
    // counter (16 bits); modulus needs 17 bits so that 2**16 fits.
    function automatic logic [15:0] clamp_load(input logic [15:0] value,
                                               input logic [16:0] modulus);
        logic [16:0] value_ext;
        value_ext = {1'b0, value};
        if (value_ext >= modulus) begin
            clamp_load = 16'(modulus - 17'd1);
        end else begin
            clamp_load = value;
        end
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: synchronous active-high reset to 0, toggles when t=1.
module tff_cell (
    input  logic clock,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_r;

    // Storage bit: clear on reset, otherwise invert when t is asserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= 1'b0;
        end else if (t) begin
            q_r <= ~q_r;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Modulo-N up/down counter built from a bank of T cells. The controller only
// computes the desired next value and turns it into per-bit toggle enables;
// the count itself lives in the tff_cell bank.
module tff_counter_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(32'd1);

    state_t           state_r;
    state_t           state_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] load_clamped_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             advance_s;
    logic             wrap_s;

    // T-cell bank holding the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .t     (t_s[i]),
            .q     (count_s[i])
        );
    end

    assign load_clamped_s = WIDTH'(clamp_load(16'(load_value), 17'(MODULUS)));
    assign at_max_s       = (count_s == MAX_C);
    assign at_zero_s      = (count_s == ZERO_C);
    // Advance only while running and not pre-empted by stop or load.
    assign advance_s      = (state_r == S_RUN) && !stop && !load;
    assign tc             = (state_r == S_RUN) && (up ? at_max_s : at_zero_s);
    assign wrap_s         = advance_s && tc;

    // Next count value: load beats advance, otherwise hold.
    always_comb begin
        next_s = count_s;
        if (load) begin
            next_s = load_clamped_s;
        end else if (advance_s) begin
            if (up) begin
                next_s = at_max_s ? ZERO_C : (count_s + ONE_C);
            end else begin
                next_s = at_zero_s ? MAX_C : (count_s - ONE_C);
            end
        end else begin
            next_s = count_s;
        end
    end

    // Toggle enables: flip exactly the bits that differ between now and next.
    assign t_s = count_s ^ next_s;

    // FSM next-state logic; stop always takes priority over start.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !stop) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_s = S_IDLE;
                end else if (oneshot && wrap_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_s = S_IDLE;
                end else if (start) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register plus registered status flags decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_RUN);
            done_r  <= (state_s == S_DONE);
        end
    end

    assign count = count_s;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench for tff_counter_ctrl: directed scenarios plus random
// stimulus against an arithmetic reference model, and a 3-bit/mod-8 instance
// whose per-cycle bit flips are compared with the classic T-counter rule.
module tb_tff_counter_ctrl;

    localparam int MOD_A = 10;
    localparam int MOD_B = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       oneshot = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    logic       b_reset = 1'b1;
    logic       b_start = 1'b0;
    logic [2:0] b_count;
    logic       b_tc;
    logic       b_busy;
    logic       b_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of instance A: count value and run/finished flags.
    int m_count = 0;
    bit m_run = 1'b0;
    bit m_fin = 1'b0;

    always #5 clock = ~clock;

    tff_counter_ctrl #(.WIDTH(4), .MODULUS(MOD_A)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .oneshot(oneshot), .up(up), .load(load), .load_value(load_value),
        .count(count), .tc(tc), .busy(busy), .done(done)
    );

    tff_counter_ctrl #(.WIDTH(3), .MODULUS(MOD_B)) dut_b (
        .clock(clock), .reset(b_reset), .start(b_start), .stop(1'b0),
        .oneshot(1'b0), .up(1'b1), .load(1'b0), .load_value(3'd0),
        .count(b_count), .tc(b_tc), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of instance A: check tc for the current inputs, advance the
    // model by the specification's rules, clock, then check registered state.
    task automatic step_a();
        int exp_tc;
        bit adv;
        bit wrap;
        #1;
        exp_tc = (m_run && ((up && m_count == MOD_A - 1) || (!up && m_count == 0))) ? 1 : 0;
        if (!reset) check("tc", int'(tc), exp_tc);
        if (reset) begin
            m_count = 0;
            m_run   = 1'b0;
            m_fin   = 1'b0;
        end else begin
            adv  = m_run && !stop && !load;
            wrap = adv && (exp_tc == 1);
            if (load) m_count = (int'(load_value) >= MOD_A) ? MOD_A - 1 : int'(load_value);
            else if (adv) m_count = up ? (m_count + 1) % MOD_A : (m_count + MOD_A - 1) % MOD_A;
            if (m_run) begin
                if (stop) m_run = 1'b0;
                else if (oneshot && wrap) begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end
            end else if (m_fin) begin
                if (stop) m_fin = 1'b0;
                else if (start) begin
                    m_fin = 1'b0;
                    m_run = 1'b1;
                end
            end else if (start && !stop) begin
                m_run = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        check("count", int'(count), m_count);
        check("busy", int'(busy), int'(m_run));
        check("done", int'(done), int'(m_fin));
    endtask

    // Classic T-counter rule: bit i toggles when all lower bits are 1.
    function automatic int classic_up_mask(input int prev, input int width);
        int mask = 0;
        for (int i = 0; i < width; i++) begin
            if ((prev & ((1 << i) - 1)) == ((1 << i) - 1)) mask |= (1 << i);
        end
        return mask;
    endfunction

    initial begin
        int prev;
        int cur;

        // Instance B: 3-bit, modulus 8, free-running up count (A held in reset).
        @(posedge clock);
        #1;
        check("b_reset_count", int'(b_count), 0);
        b_reset = 1'b0;
        b_start = 1'b1;
        @(posedge clock);
        #1;
        b_start = 1'b0;
        check("b_start_busy", int'(b_busy), 1);
        prev = int'(b_count);
        check("b_start_count", prev, 0);
        for (int k = 0; k < 18; k++) begin
            check("b_tc", int'(b_tc), (prev == MOD_B - 1) ? 1 : 0);
            @(posedge clock);
            #1;
            cur = int'(b_count);
            check("b_count", cur, (prev + 1) % MOD_B);
            check("b_toggle_mask", prev ^ cur, classic_up_mask(prev, 3));
            prev = cur;
        end

        // Instance A: reset state.
        reset = 1'b1; step_a(); reset = 1'b0;
        check("reset_count", int'(count), 0);
        check("reset_busy", int'(busy), 0);

        // Free-run up through the wrap 9 -> 0.
        up = 1'b1; oneshot = 1'b0; start = 1'b1; step_a(); start = 1'b0;
        repeat (11) step_a();
        check("freerun_after_wrap", int'(count), 1);
        stop = 1'b1; step_a(); stop = 1'b0;

        // Load 5 in IDLE, one-shot down: 5,4,3,2,1,0,9 then DONE holding 9.
        load = 1'b1; load_value = 4'd5; step_a(); load = 1'b0;
        up = 1'b0; oneshot = 1'b1; start = 1'b1; step_a(); start = 1'b0;
        repeat (8) step_a();
        check("oneshot_done", int'(done), 1);
        check("oneshot_hold", int'(count), 9);
        check("oneshot_not_busy", int'(busy), 0);

        // Stop at 3, restart two cycles later and continue 4,5.
        load = 1'b1; load_value = 4'd2; step_a(); load = 1'b0;
        up = 1'b1; oneshot = 1'b0; start = 1'b1; step_a(); start = 1'b0;
        step_a();
        stop = 1'b1; step_a(); stop = 1'b0;
        check("stop_hold", int'(count), 3);
        check("stop_idle", int'(busy), 0);
        repeat (2) step_a();
        start = 1'b1; step_a(); start = 1'b0;
        repeat (2) step_a();
        check("restart_count", int'(count), 5);
        stop = 1'b1; step_a(); stop = 1'b0;

        // Start and stop together from IDLE: stop wins.
        start = 1'b1; stop = 1'b1; step_a(); start = 1'b0; stop = 1'b0;
        check("start_stop_idle", int'(busy), 0);
        check("start_stop_count", int'(count), 5);

        // Out-of-range load clamps to MODULUS-1.
        load = 1'b1; load_value = 4'd15; step_a(); load = 1'b0;
        check("clamp_load", int'(count), 9);

        // Reset mid-run at 6.
        load = 1'b1; load_value = 4'd5; step_a(); load = 1'b0;
        start = 1'b1; step_a(); start = 1'b0;
        step_a();
        check("run_at_6", int'(count), 6);
        reset = 1'b1; step_a(); reset = 1'b0;
        check("midrun_reset_count", int'(count), 0);
        check("midrun_reset_done", int'(done), 0);

        // Load and reset together: reset wins.
        load = 1'b1; load_value = 4'd7; reset = 1'b1; step_a(); load = 1'b0; reset = 1'b0;
        check("load_reset", int'(count), 0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            start      = ($urandom_range(7) == 0);
            stop       = ($urandom_range(15) == 0);
            load       = ($urandom_range(15) == 0);
            load_value = 4'($urandom_range(15));
            if ($urandom_range(9) == 0) up = ~up;
            if ($urandom_range(19) == 0) oneshot = ~oneshot;
            reset      = ($urandom_range(63) == 0);
            step_a();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
